imem_fetch_ctrl: RTL
====================

# imem_fetch_ctrl

Instruction-fetch sequencer for the single-cycle MIPS core's byte-addressed, combinational-read instruction memory (256 bytes, big-endian 32-bit words). It owns the program counter and drives the memory read address. It buffers fetched words in a 2-entry queue with a valid/ready handshake to decode. It resolves `j` locally, accepts redirects (taken `beq`, exceptions) from downstream, and traps out-of-range or misaligned fetch addresses.

## Interface
Parameters:
- `IMEM_BYTES`, 256: instruction memory size in bytes. Legal fetch PCs are 0..`IMEM_BYTES`-4, word aligned.
- `RESET_PC`, 0: PC loaded on reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: fetch enable. 0 freezes the PC and performs no fetches. Queue pops still allowed.
- `imem_addr` out 32: read address to instruction memory. Always equals the PC register.
- `imem_data` in 32: combinational read word for `imem_addr`, valid in the same cycle.
- `inst_out` out 32: instruction word at queue head.
- `inst_pc` out 32: byte PC of `inst_out`.
- `inst_valid` out 1: queue head valid.
- `inst_ready` in 1: decode accepts head. A pop happens when `inst_valid & inst_ready`.
- `redirect_valid` in 1: one-cycle request to restart fetch at `redirect_pc`.
- `redirect_pc` in 32: redirect target (byte address).
- `fault` out 1: sticky fetch fault.
- `fault_pc` out 32: offending PC, captured on fault entry.

## Operation
- States: FETCH and FAULT. Reset enters FETCH.
- Reset values:
  - PC = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - Queue is empty, so `inst_valid` = 0.
  - `inst_out` = 0, `inst_pc` = 0, `fault` = 0, `fault_pc` = 0.
- Per-cycle priority in FETCH:
  1. **redirect**
  2. **fetch**
  3. **idle**
- Redirect (`redirect_valid`=1):
  - If `redirect_pc[1:0]`≠0 or `redirect_pc` > `IMEM_BYTES`-4: enter FAULT, `fault_pc` = `redirect_pc`.
  - Otherwise: PC ← `redirect_pc`, the queue is flushed, and no fetch occurs this cycle.
  - A pop in the same cycle counts as accepted. The flush then discards all remaining entries.
- Fetch condition: no redirect, `run`=1, and (count<2 or pop this cycle).
  - If the PC is out of range: enter FAULT with `fault_pc` = PC. Nothing is enqueued.
  - Otherwise: enqueue {PC, `imem_data`}, then compute the next PC:
    - If `imem_data[31:26]`=6'b000010 (`j`): PC ← {(PC+4)[31:28], `imem_data[25:0]`, 2'b00}. The `j` word itself is still enqueued.
    - Else: PC ← PC+4, 32-bit wrap with no carry-out. Out-of-range detection catches overflow on the next fetch attempt.
- `beq` and all other opcodes are not interpreted. Decode reports taken branches via redirect.
- Queue:
  - 2-entry FIFO, in-order delivery, no drops and no duplicates.
  - Push and pop in the same cycle are legal when full or when holding one entry.
  - A pop while empty is ignored.
- FAULT: sticky until `reset`.
  - Queue flushed, `inst_valid`=0.
  - PC and `imem_addr` held.
  - `redirect_valid` and `run` ignored.
  - `fault`=1.

## Timing
- Registered PC: `imem_addr` changes only on the clock edge following a fetch or redirect, or asynchronously on reset.
- Fetch latency: a word addressed in cycle N appears at the head (`inst_valid`=1) in cycle N+1 if the queue was empty. No combinational path from `imem_data` to `inst_out`.
- Throughput: one instruction per cycle with `inst_ready` held at 1.
- Redirect latency:
  - Redirect in cycle N → `imem_addr` = target in N+1, `inst_valid`=0 in N+1.
  - Target instruction at the head in N+2.
- `inst_ready`→fetch is a combinational path. A pop frees a slot for a fetch in the same cycle.
- Reset asserted mid-operation: all state is cleared immediately (asynchronously), including any buffered entries and FAULT.

## Test plan
- Reset, then `run`=1, `inst_ready`=1, memory word0=0x8C080000, word4=0x8C090001 → first valid cycle `inst_out`=0x8C080000 with `inst_pc`=0, next cycle 0x8C090001 with `inst_pc`=4, `imem_addr` stepping 0,4,8.
- `inst_ready`=0 for 5 cycles after first fetch → count saturates at 2 and `imem_addr` holds 8. On release, deliveries are pc 0,4,8 in order with no gaps beyond one cycle.
- Word at 52 = 0x08000002 → delivered with `inst_pc`=52. The next `imem_addr` is 8; pc 56 is never fetched.
- Queue holding pc 12,16, `redirect_valid`=1 with `redirect_pc`=80 → next cycle `inst_valid`=0, `imem_addr`=80; following cycle `inst_pc`=80. Entries 12 and 16 are never delivered.
- Fault cases:
  - Redirect to 0x102 → `fault`=1, `fault_pc`=0x102, `inst_valid` stays 0, later redirects ignored.
  - Separately, sequential run from 248 → pc 248 and 252 delivered, then `fault`=1 with `fault_pc`=256.
- `reset` pulsed while in FAULT with the queue non-empty → same cycle: `fault`=0, `inst_valid`=0, `imem_addr`=0. Normal fetch resumes from 0 after release.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl_if
//  Description : Bundle between the fetch sequencer, the instruction memory
//                and decode. Holds the memory read path, the instruction queue
//                handshake, the redirect request and the fault report.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_fetch_ctrl_if;
  logic        run;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  // Fetch sequencer side
  modport master (
    input  run,
    output imem_addr,
    input  imem_data,
    output inst_out,
    output inst_pc,
    output inst_valid,
    input  inst_ready,
    input  redirect_valid,
    input  redirect_pc,
    output fault,
    output fault_pc
  );

  // Memory / decode / control side
  modport slave (
    output run,
    input  imem_addr,
    output imem_data,
    input  inst_out,
    input  inst_pc,
    input  inst_valid,
    output inst_ready,
    output redirect_valid,
    output redirect_pc,
    input  fault,
    input  fault_pc
  );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl
//  Description : Instruction-fetch sequencer. Owns the PC, reads a
//                combinational instruction memory, buffers words in a 2-entry
//                queue towards decode, resolves `j` locally, accepts
//                redirects and traps illegal fetch addresses (sticky FAULT).
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
  parameter int unsigned IMEM_BYTES = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  imem_fetch_ctrl_if.master  bus
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  localparam logic [31:0] c_max_pc = 32'(IMEM_BYTES - 4);
  localparam logic [5:0]  c_op_j   = 6'b000010;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [1:0]  cnt_q, cnt_d;
  // Entry 0 is always the queue head; entry 1 is the tail when two are held.
  logic [31:0] e0_pc_q, e0_pc_d, e0_inst_q, e0_inst_d;
  logic [31:0] e1_pc_q, e1_pc_d, e1_inst_q, e1_inst_d;

  logic        w_valid;
  logic        w_pop;
  logic        w_pc_bad;
  logic        w_redir_bad;
  logic        w_is_j;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_pc;

  // The queue is always empty in FAULT, so a non-zero count alone means valid.
  assign w_valid     = (cnt_q != 2'd0);
  assign w_pop       = w_valid & bus.inst_ready;
  assign w_pc_bad    = (pc_q[1:0] != 2'b00) || (pc_q > c_max_pc);
  assign w_redir_bad = (bus.redirect_pc[1:0] != 2'b00) || (bus.redirect_pc > c_max_pc);
  assign w_is_j      = (bus.imem_data[31:26] == c_op_j);
  assign w_pc_plus4  = pc_q + 32'd4;
  assign w_jump_pc   = {w_pc_plus4[31:28], bus.imem_data[25:0], 2'b00};

  // Next-state: redirect beats fetch; pop is applied before the push so a
  // full queue can accept a new word in the same cycle it delivers one.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    cnt_d      = cnt_q;
    e0_pc_d    = e0_pc_q;
    e0_inst_d  = e0_inst_q;
    e1_pc_d    = e1_pc_q;
    e1_inst_d  = e1_inst_q;

    case (state_q)
      S_FETCH: begin
        if (bus.redirect_valid) begin
          cnt_d = 2'd0;
          if (w_redir_bad) begin
            state_d    = S_FAULT;
            fault_pc_d = bus.redirect_pc;
          end else begin
            pc_d = bus.redirect_pc;
          end
        end else begin
          if (w_pop) begin
            e0_pc_d   = e1_pc_q;
            e0_inst_d = e1_inst_q;
            cnt_d     = cnt_q - 2'd1;
          end
          if (bus.run && ((cnt_q != 2'd2) || w_pop)) begin
            if (w_pc_bad) begin
              state_d    = S_FAULT;
              fault_pc_d = pc_q;
              cnt_d      = 2'd0;
            end else begin
              if (cnt_d == 2'd0) begin
                e0_pc_d   = pc_q;
                e0_inst_d = bus.imem_data;
              end else begin
                e1_pc_d   = pc_q;
                e1_inst_d = bus.imem_data;
              end
              cnt_d = cnt_d + 2'd1;
              pc_d  = w_is_j ? w_jump_pc : w_pc_plus4;
            end
          end
        end
      end
      default: begin
        // FAULT is sticky: PC held, queue empty, redirects and run ignored.
        cnt_d = 2'd0;
      end
    endcase
  end

  // State register with asynchronous clear of PC, queue and fault capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      fault_pc_q <= 32'h0;
      cnt_q      <= 2'd0;
      e0_pc_q    <= 32'h0;
      e0_inst_q  <= 32'h0;
      e1_pc_q    <= 32'h0;
      e1_inst_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      cnt_q      <= cnt_d;
      e0_pc_q    <= e0_pc_d;
      e0_inst_q  <= e0_inst_d;
      e1_pc_q    <= e1_pc_d;
      e1_inst_q  <= e1_inst_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.inst_out   = e0_inst_q;
  assign bus.inst_pc    = e0_pc_q;
  assign bus.inst_valid = w_valid;
  assign bus.fault      = (state_q == S_FAULT);
  assign bus.fault_pc   = fault_pc_q;

endmodule
`default_nettype wire
